// File: rtl/jpeg_out_pkg.sv
// Pixel format constants, packing helper and FIFO entry type for the pixel output stage.
// Output format is selected by JPEG_OUT_RGB565_EN (RGB565 when defined, 0RGB888 otherwise).
package jpeg_out_pkg;

    localparam int PIX_BYTES_888 = 4;
    localparam int PIX_BYTES_565 = 2;
    localparam int PIX_SHIFT_888 = $clog2(PIX_BYTES_888);
    localparam int PIX_SHIFT_565 = $clog2(PIX_BYTES_565);

    localparam int DEF_ADDR_W = 32;
    localparam int OUT_DATA_W = 32;

`ifdef JPEG_OUT_RGB565_EN
    localparam int PIX_DATA_W = 16;
    localparam int PIX_SHIFT  = PIX_SHIFT_565;
`else
    localparam int PIX_DATA_W = 24;
    localparam int PIX_SHIFT  = PIX_SHIFT_888;
`endif

    typedef logic [PIX_DATA_W-1:0] pix_data_t;

    // Entry layout for stages that use the default address width.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        pix_data_t             data;
    } fifo_entry_t;

    function automatic pix_data_t pack_pixel(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
`ifdef JPEG_OUT_RGB565_EN
        return {r[7:3], g[7:2], b[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

endpackage

// File: rtl/jpeg_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is valid whenever empty is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module jpeg_pixel_fifo #(
    parameter int AW = 5,
    parameter int DW = 56
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Zero while empty so the outputs read as idle straight out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst) count <= (AW+1)'(DEPTH));

endmodule

// File: rtl/jpeg_pixel_out.sv
// Turns the decoder's RGB pixel stream into linear frame-buffer write requests.
// Pixel packing and address step follow JPEG_OUT_RGB565_EN (see jpeg_out_pkg).
module jpeg_pixel_out
    import jpeg_out_pkg::*;
#(
    parameter int FIFO_AW      = 5,
    parameter int AFULL_MARGIN = 8,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  InEnable,
    input  logic [15:0]           InPixelX,
    input  logic [15:0]           InPixelY,
    input  logic [7:0]            InR,
    input  logic [7:0]            InG,
    input  logic [7:0]            InB,
    output logic                  InAlmostFull,
    input  logic [15:0]           ImageWidth,
    input  logic [ADDR_W-1:0]     BaseAddress,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [ADDR_W-1:0]     OutAddress,
    output logic [OUT_DATA_W-1:0] OutData,
    output logic                  Overflow,
    input  logic                  ClearOvf
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pix_data_t         data;
    } entry_t;

    localparam int EW          = $bits(entry_t);
    localparam int DEPTH       = 1 << FIFO_AW;
    localparam int AFULL_LEVEL = DEPTH - AFULL_MARGIN;

    logic              s1_valid;
    logic [31:0]       s1_row_base;
    logic [15:0]       s1_x;
    pix_data_t         s1_data;

    logic              s2_valid;
    entry_t            s2_entry;
    logic [ADDR_W-1:0] s2_addr_next;

    entry_t            fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;

    logic              pop_fire;
    logic              drop;
    logic [FIFO_AW+1:0] occupancy;
    logic              afull_q;
    logic              ovf_q;

    // Stage 1: row base product, the only wide multiply on the path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_row_base <= '0;
            s1_x        <= '0;
            s1_data     <= '0;
        end else begin
            s1_valid <= InEnable;
            if (InEnable) begin
                s1_row_base <= 32'(InPixelY) * 32'(ImageWidth);
                s1_x        <= InPixelX;
                s1_data     <= pack_pixel(InR, InG, InB);
            end
        end
    end

    assign s2_addr_next = BaseAddress
                        + ((ADDR_W'(s1_row_base) + ADDR_W'(s1_x)) << PIX_SHIFT);

    // Stage 2: final address; its valid is the FIFO push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry <= '{addr: s2_addr_next, data: s1_data};
            end
        end
    end

    jpeg_pixel_fifo #(
        .AW (FIFO_AW),
        .DW (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .wdata (s2_entry),
        .pop   (pop_fire),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign OutValid   = !fifo_empty;
    assign pop_fire   = OutValid && OutReady;
    assign OutAddress = fifo_rdata.addr;
    assign OutData    = OUT_DATA_W'(fifo_rdata.data);

    assign drop = s2_valid && fifo_full && !pop_fire;

    // Pixels still in the pipeline count against the reserve so the throttle
    // covers everything the decoder has already handed over.
    assign occupancy = (FIFO_AW+2)'(fifo_count)
                     + (FIFO_AW+2)'(s1_valid)
                     + (FIFO_AW+2)'(s2_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            afull_q <= (occupancy > (FIFO_AW+2)'(AFULL_LEVEL));
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ClearOvf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign InAlmostFull = afull_q;
    assign Overflow     = ovf_q;

endmodule
